cache_wb_buffer: RTL and testbench
==================================

CACHE_WB_BUFFER -- requirements
Module: cache_wb_buffer

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the number of 32-bit words per cache line (power of two, 2..16).
REQ-002 The block SHALL have parameter LOG_W, default 2, equal to log2(W).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-004 The block SHALL have port resetn, input, 1 bit, a synchronous active-low reset.
REQ-005 The block SHALL have port push_valid, input, 1 bit, set when the cache offers an evicted dirty line.
REQ-006 The block SHALL have port push_ready, output, 1 bit, set when the buffer can accept a line.
REQ-007 The block SHALL have port push_addr, input, 32 bits, the line address (bits [LOG_W+1:0] ignored).
REQ-008 The block SHALL have port push_line, input, W*32 bits, the victim line from the data RAM line output (word k at [32k+31:32k]).
REQ-009 The block SHALL have ports wr_req (output, 1), wr_addr (output, 32) and wr_rdy (input, 1), forming the memory write-address handshake.
REQ-010 The block SHALL have ports wr_data (output, 32), wr_data_valid (output, 1), wr_data_last (output, 1) and wr_data_ready (input, 1), forming the write-data beat handshake.
REQ-011 The block SHALL have port wr_bvalid, input, 1 bit, the memory write-complete response.
REQ-012 The block SHALL have port busy, output, 1 bit, set when the state is not IDLE.

Function
REQ-013 The block SHALL implement FSM states IDLE, REQ, DATA and RESP.
REQ-014 In IDLE, push_ready SHALL be 1; on push_valid=1 it SHALL latch push_addr (low LOG_W+2 bits zeroed) and push_line, clear the beat counter and go to REQ on the next edge.
REQ-015 In REQ, wr_req SHALL be 1 with wr_addr equal to the latched address; on wr_rdy=1 it SHALL go to DATA.
REQ-016 In DATA, wr_data_valid SHALL be 1 and wr_data SHALL equal latched word[beat]; on wr_data_ready=1 the beat SHALL increment.
REQ-017 wr_data_last SHALL be 1 only when beat==W-1 in DATA; a handshake on that beat SHALL move to RESP.
REQ-018 The beat counter SHALL be LOG_W bits wide and SHALL never wrap within one line.
REQ-019 In RESP, the block SHALL wait for wr_bvalid=1, then return to IDLE; push_ready SHALL rise the cycle after.
REQ-020 wr_bvalid outside RESP SHALL be ignored.
REQ-021 push_ready SHALL be 0 in every state except IDLE; a push_valid with push_ready=0 SHALL be ignored and SHALL not corrupt the latched line.
REQ-022 wr_req, wr_data_valid and wr_addr/wr_data SHALL stay stable while their ready input is low.
REQ-023 A line SHALL be written in at least W+3 cycles from push to IDLE (1 REQ, W DATA, 1 RESP, 1 accept), with no bubbles when all readies are held high.

Reset
REQ-024 When resetn=0 at a clk edge, the state SHALL become IDLE, the beat SHALL become 0 and the latched address and line SHALL become 0.
REQ-025 After reset, wr_req, wr_data_valid, wr_data_last and busy SHALL be 0, push_ready SHALL be 1, and wr_addr and wr_data SHALL be 0.
REQ-026 A reset taken in mid-operation (REQ, DATA or RESP) SHALL abandon the transfer without issuing further beats.

Configuration
REQ-027 When WB_FORWARD_EN is defined, the block SHALL add ports fwd_addr (input, 32), fwd_hit (output, 1) and fwd_data (output, 32).
REQ-028 With WB_FORWARD_EN, fwd_hit SHALL be combinationally 1 when busy=1 and fwd_addr[31:LOG_W+2] equals the latched line address, and fwd_data SHALL be the latched word fwd_addr[LOG_W+1:2]; otherwise fwd_hit=0 and fwd_data=0.
REQ-029 Without WB_FORWARD_EN, those ports and their logic SHALL be absent.

Verification
REQ-030 Nominal case: push addr 0x1000_0044 with line {0xD,0xC,0xB,0xA} and all readies high -> wr_addr=0x1000_0040; beats 0xA,0xB,0xC,0xD; last on the 4th beat; push_ready returns W+3 cycles after push.
REQ-031 Backpressure: wr_data_ready toggles 1,0,1,0 -> each beat is held stable and no beat is dropped or repeated.
REQ-032 Busy push: push_valid in DATA with a different line -> it is ignored and the original data completes.
REQ-033 Mid-DATA reset after 2 beats -> the next cycle shows IDLE with push_ready=1 and wr_data_valid=0.
REQ-034 With WB_FORWARD_EN: fwd_addr=0x1000_0048 during DATA -> fwd_hit=1, fwd_data=0xC; after RESP completes -> fwd_hit=0.
REQ-035 Late response: wr_bvalid is delayed 5 cycles -> the block stays in RESP with busy=1, then returns to IDLE.

Source files
------------

// File: rtl/cache_wb_buffer.sv
// Write-back buffer: holds one evicted dirty line and streams it to memory as an
// address phase, W data beats and a write response. Optional build macro WB_FORWARD_EN adds a read-forward port.
module cache_wb_buffer #(
  parameter int W     = 4,
  parameter int LOG_W = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            push_valid,
  output logic            push_ready,
  input  logic [31:0]     push_addr,
  input  logic [W*32-1:0] push_line,
  output logic            wr_req,
  output logic [31:0]     wr_addr,
  input  logic            wr_rdy,
  output logic [31:0]     wr_data,
  output logic            wr_data_valid,
  output logic            wr_data_last,
  input  logic            wr_data_ready,
  input  logic            wr_bvalid,
  output logic            busy
`ifdef WB_FORWARD_EN
  ,
  input  logic [31:0]     fwd_addr,
  output logic            fwd_hit,
  output logic [31:0]     fwd_data
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [31:0]      ADDR_MASK = ~((32'd1 << (LOG_W + 2)) - 32'd1);
  localparam logic [LOG_W-1:0] BEAT_LAST = LOG_W'(W - 1);

  state_t            r_state;
  state_t            w_next;
  logic [LOG_W-1:0]  r_beat;
  logic [31:0]       r_addr;
  logic [W*32-1:0]   r_line;
  logic [31:0]       w_words [W];
  logic              w_accept;
  logic              w_beat_adv;
  logic              w_is_last;

  // Split the latched line into addressable 32-bit words.
  always_comb begin
    for (int k = 0; k < W; k++) begin
      w_words[k] = r_line[32*k +: 32];
    end
  end

  assign w_is_last = (r_beat == BEAT_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs, all decoded from the registered state.
  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_beat_adv    = 1'b0;
    push_ready    = 1'b0;
    wr_req        = 1'b0;
    wr_addr       = 32'd0;
    wr_data_valid = 1'b0;
    wr_data       = 32'd0;
    wr_data_last  = 1'b0;
    busy          = 1'b1;
    case (r_state)
      IDLE: begin
        push_ready = 1'b1;
        busy       = 1'b0;
        if (push_valid) begin
          w_accept = 1'b1;
          w_next   = REQ;
        end else begin
          w_next   = IDLE;
        end
      end
      REQ: begin
        wr_req  = 1'b1;
        wr_addr = r_addr;
        if (wr_rdy) begin
          w_next = DATA;
        end else begin
          w_next = REQ;
        end
      end
      DATA: begin
        wr_data_valid = 1'b1;
        wr_data       = w_words[r_beat];
        wr_data_last  = w_is_last;
        if (wr_data_ready) begin
          w_beat_adv = 1'b1;
          w_next     = w_is_last ? RESP : DATA;
        end else begin
          w_next     = DATA;
        end
      end
      RESP: begin
        if (wr_bvalid) begin
          w_next = IDLE;
        end else begin
          w_next = RESP;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Line latch and beat counter; the counter parks on the last beat instead of wrapping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_addr <= 32'd0;
      r_line <= '0;
      r_beat <= '0;
    end else if (w_accept) begin
      r_addr <= push_addr & ADDR_MASK;
      r_line <= push_line;
      r_beat <= '0;
    end else if (w_beat_adv && !w_is_last) begin
      r_beat <= r_beat + LOG_W'(1);
    end else begin
      r_beat <= r_beat;
    end
  end

`ifdef WB_FORWARD_EN
  // Forward a word of the in-flight line to a reader hitting the same line.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 32'd0;
    if (busy && ((fwd_addr & ADDR_MASK) == r_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = w_words[fwd_addr[LOG_W+1:2]];
    end else begin
      fwd_hit  = 1'b0;
      fwd_data = 32'd0;
    end
  end
`endif

endmodule

// File: tb/tb_cache_wb_buffer.sv
// Self-checking bench for cache_wb_buffer: directed vector table, hand-written
// reset sequences and randomized traffic against a transaction-level model.
module tb_cache_wb_buffer;
  localparam int W     = 4;
  localparam int LOG_W = 2;
  localparam logic [31:0] AMASK = 32'hFFFF_FFF0;

  logic            clk = 1'b0;
  logic            resetn;
  logic            push_valid;
  logic            push_ready;
  logic [31:0]     push_addr;
  logic [W*32-1:0] push_line;
  logic            wr_req;
  logic [31:0]     wr_addr;
  logic            wr_rdy;
  logic [31:0]     wr_data;
  logic            wr_data_valid;
  logic            wr_data_last;
  logic            wr_data_ready;
  logic            wr_bvalid;
  logic            busy;
`ifdef WB_FORWARD_EN
  logic [31:0]     fwd_addr;
  logic            fwd_hit;
  logic [31:0]     fwd_data;
`endif

  always #5 clk = ~clk;

  cache_wb_buffer #(.W(W), .LOG_W(LOG_W)) dut (
    .clk(clk), .resetn(resetn),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_addr(push_addr), .push_line(push_line),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_rdy(wr_rdy),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid),
    .wr_data_last(wr_data_last), .wr_data_ready(wr_data_ready),
    .wr_bvalid(wr_bvalid), .busy(busy)
`ifdef WB_FORWARD_EN
    , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  // Transaction-level model: one outstanding line, address sent, beats sent.
  bit              m_busy = 1'b0;
  bit              m_addr_done = 1'b0;
  int              m_beats = 0;
  logic [31:0]     m_addr = 32'd0;
  logic [W*32-1:0] m_line = '0;
  int              lines_done = 0;

  logic [31:0]     cap_addr;
  int              cap_beats;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    bit exp_req, exp_dv;
    exp_req = m_busy && !m_addr_done;
    exp_dv  = m_busy && m_addr_done && (m_beats < W);
    chk("push_ready", push_ready, !m_busy);
    chk("busy", busy, m_busy);
    chk("wr_req", wr_req, exp_req);
    chk("wr_data_valid", wr_data_valid, exp_dv);
    if (exp_req) chk("wr_addr", wr_addr, m_addr);
    if (exp_dv) begin
      chk("wr_data", wr_data, m_line[32*m_beats +: 32]);
      chk("wr_data_last", wr_data_last, (m_beats == W - 1));
    end else begin
      chk("wr_data_last_idle", wr_data_last, 1'b0);
    end
`ifdef WB_FORWARD_EN
    if (m_busy && ((fwd_addr & AMASK) == m_addr)) begin
      chk("fwd_hit", fwd_hit, 1'b1);
      chk("fwd_data", fwd_data, m_line[32*fwd_addr[3:2] +: 32]);
    end else begin
      chk("fwd_hit", fwd_hit, 1'b0);
      chk("fwd_data", fwd_data, 32'd0);
    end
`endif
    if (!resetn) begin
      m_busy = 1'b0; m_addr_done = 1'b0; m_beats = 0;
    end else if (!m_busy) begin
      if (push_valid) begin
        m_busy = 1'b1; m_addr_done = 1'b0; m_beats = 0;
        m_addr = push_addr & AMASK; m_line = push_line;
      end
    end else if (!m_addr_done) begin
      if (wr_rdy) begin
        m_addr_done = 1'b1;
        cap_addr = wr_addr;
      end
    end else if (m_beats < W) begin
      if (wr_data_ready) begin
        m_beats++;
        cap_beats++;
      end
    end else if (wr_bvalid) begin
      m_busy = 1'b0;
      lines_done++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0]     addr;
    logic [W*32-1:0] line;
    logic [15:0]     rq_pat;
    logic [15:0]     dr_pat;
    logic [15:0]     bv_pat;
    bit              busy_push;
    logic [31:0]     exp_addr;
    int              exp_cycles;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n;
    vecs[0] = '{32'h1000_0044, {32'hD, 32'hC, 32'hB, 32'hA}, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 32'h1000_0040, 7};
    vecs[1] = '{32'h2000_0008, {32'h44, 32'h33, 32'h22, 32'h11}, 16'hFFFF, 16'h5555, 16'hFFFF, 1'b0, 32'h2000_0000, 10};
    vecs[2] = '{32'h3000_001C, {32'hCAFE, 32'hBEEF, 32'hF00D, 32'hFEED}, 16'hFFFF, 16'hFFFF, 16'hF800, 1'b0, 32'h3000_0010, 12};
    vecs[3] = '{32'h4000_0030, {32'h4, 32'h3, 32'h2, 32'h1}, 16'hFFF9, 16'hFFFF, 16'hFFFF, 1'b0, 32'h4000_0030, 9};
    vecs[4] = '{32'h5000_FFFC, {32'h5D, 32'h5C, 32'h5B, 32'h5A}, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 32'h5000_FFF0, 7};

    resetn = 1'b0; push_valid = 1'b0; push_addr = 32'd0; push_line = '0;
    wr_rdy = 1'b0; wr_data_ready = 1'b0; wr_bvalid = 1'b0;
`ifdef WB_FORWARD_EN
    fwd_addr = 32'h1000_0048;
`endif
    @(posedge clk); #1;
    step(); step();
    chk("rst_push_ready", push_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_req", wr_req, 1'b0);
    chk("rst_wr_data_valid", wr_data_valid, 1'b0);
    chk("rst_wr_data_last", wr_data_last, 1'b0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    resetn = 1'b1;
    step();

    // Directed vectors: latency from push to push_ready, address and beat count.
    for (int i = 0; i < 5; i++) begin
      cap_addr = 32'hDEAD_DEAD; cap_beats = 0; n = 0;
      push_valid = 1'b1; push_addr = vecs[i].addr; push_line = vecs[i].line;
      wr_rdy = vecs[i].rq_pat[0]; wr_data_ready = vecs[i].dr_pat[0]; wr_bvalid = vecs[i].bv_pat[0];
      step(); n = 1;
      push_valid = vecs[i].busy_push; push_line = ~vecs[i].line; push_addr = vecs[i].addr ^ 32'h100;
      while (!push_ready && n < 64) begin
        wr_rdy = vecs[i].rq_pat[n % 16]; wr_data_ready = vecs[i].dr_pat[n % 16];
        wr_bvalid = vecs[i].bv_pat[n % 16];
        step(); n++;
      end
      push_valid = 1'b0; wr_bvalid = 1'b0;
      chk($sformatf("vec%0d_cycles", i), n, vecs[i].exp_cycles);
      chk($sformatf("vec%0d_addr", i), cap_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_beats", i), cap_beats, W);
      step();
    end

    // Mid-DATA reset after two beats abandons the line.
    push_valid = 1'b1; push_addr = 32'h6000_0000; push_line = {32'h64, 32'h63, 32'h62, 32'h61};
    wr_rdy = 1'b1; wr_data_ready = 1'b1; wr_bvalid = 1'b0;
    step(); push_valid = 1'b0;
    n = 0;
    while (m_beats < 2 && n < 20) begin step(); n++; end
    chk("mid_beats", m_beats, 2);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("mid_rst_push_ready", push_ready, 1'b1);
    chk("mid_rst_valid", wr_data_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    wr_bvalid = 1'b1;
    for (int k = 0; k < 6; k++) step();

    // Randomized traffic with random backpressure and ignored busy pushes.
    for (int c = 0; c < 1500; c++) begin
      push_valid = ($urandom_range(0, 3) == 0);
      push_addr = $urandom;
      push_line = {$urandom, $urandom, $urandom, $urandom};
      wr_rdy = ($urandom_range(0, 3) != 0);
      wr_data_ready = ($urandom_range(0, 3) != 0);
      wr_bvalid = ($urandom_range(0, 2) == 0);
`ifdef WB_FORWARD_EN
      fwd_addr = $urandom_range(0, 1) ? (m_addr | {28'd0, 2'($urandom_range(0, 3)), 2'b00}) : $urandom;
`endif
      step();
    end
    push_valid = 1'b0; wr_rdy = 1'b1; wr_data_ready = 1'b1; wr_bvalid = 1'b1;
    n = 0;
    while (m_busy && n < 50) begin step(); n++; end
    step();
    chk("rand_drained", m_busy, 1'b0);
    chk("rand_progress", (lines_done > 20), 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
